// File: rtl/uvma_rvfi_retire_sched.sv
// Merges NRET RVFI retirement channels into one stream ordered by rvfi_order.
// Each channel is buffered in a small FIFO; a stall watchdog resynchronises on gaps.
module uvma_rvfi_retire_sched #(
  parameter int unsigned         NRET        = 2,
  parameter int unsigned         ORDER_WL    = 64,
  parameter int unsigned         PAYLOAD_W   = 128,
  parameter int unsigned         DEPTH       = 4,
  parameter int unsigned         STALL_LIMIT = 16,
  parameter logic [ORDER_WL-1:0] ORDER_START = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRET-1:0]           in_valid,
  output logic [NRET-1:0]           in_ready,
  input  logic [NRET*ORDER_WL-1:0]  in_order,
  input  logic [NRET*PAYLOAD_W-1:0] in_payload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ORDER_WL-1:0]       out_order,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [ORDER_WL-1:0]       expected,
  output logic                      dup_err,
  output logic                      gap_err,
  output logic [1:0]                state_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SelW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int unsigned CntW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StResync = 2'd2
  } state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [ORDER_WL-1:0]  expected_q;

  logic [NRET-1:0]      empty;
  logic [NRET-1:0]      full;
  logic [NRET-1:0]      push;
  logic [NRET-1:0]      pop;
  logic [NRET-1:0]      match;
  logic [ORDER_WL-1:0]  head_order   [NRET];
  logic [PAYLOAD_W-1:0] head_payload [NRET];

  logic                 any_match;
  logic                 any_head;
  logic                 multi_match;
  logic [SelW-1:0]      sel;
  logic                 min_found;
  logic [ORDER_WL-1:0]  min_order;
  logic                 can_load;
  logic                 load;

  assign push     = in_valid & ~full;
  assign in_ready = ~full;
  assign expected = expected_q;
  assign state_o  = state_q;

  for (genvar g = 0; g < NRET; g++) begin : g_fifo
    logic [ORDER_WL-1:0]  ord_mem [DEPTH];
    logic [PAYLOAD_W-1:0] pay_mem [DEPTH];
    logic [PtrW:0]        wr_ptr;
    logic [PtrW:0]        rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty[g] = (wr_ptr == rd_ptr);
    assign full[g]  = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                      (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign head_order[g]   = ord_mem[rd_ptr[PtrW-1:0]];
    assign head_payload[g] = pay_mem[rd_ptr[PtrW-1:0]];
    assign match[g]        = !empty[g] && (head_order[g] == expected_q);

    always_ff @(posedge clk) begin
      if (push[g]) begin
        ord_mem[wr_ptr[PtrW-1:0]] <= in_order[g*ORDER_WL +: ORDER_WL];
        pay_mem[wr_ptr[PtrW-1:0]] <= in_payload[g*PAYLOAD_W +: PAYLOAD_W];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + (PtrW+1)'(1);
        if (pop[g])  rd_ptr <= rd_ptr + (PtrW+1)'(1);
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (match[i]) sel = SelW'(i);
    end
    any_match   = |match;
    any_head    = ~&empty;
    multi_match = (match & (match - NRET'(1))) != '0;

    // Strict compare keeps the lowest index on equal orders.
    min_found = 1'b0;
    min_order = '0;
    for (int i = 0; i < NRET; i++) begin
      if (!empty[i] && (!min_found || head_order[i] < min_order)) begin
        min_found = 1'b1;
        min_order = head_order[i];
      end
    end

    can_load = !out_valid || out_ready;
    load     = can_load && any_match && (state_q != StResync);
    pop      = load ? (NRET'(1) << sel) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      expected_q  <= ORDER_START;
      dup_err     <= 1'b0;
      gap_err     <= 1'b0;
      out_valid   <= 1'b0;
      out_order   <= '0;
      out_payload <= '0;
    end else begin
      if (load) begin
        out_valid   <= 1'b1;
        out_order   <= head_order[sel];
        out_payload <= head_payload[sel];
        expected_q  <= expected_q + ORDER_WL'(1);
        if (multi_match) dup_err <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state_q)
        StRun: begin
          if (!any_match && any_head && can_load) begin
            state_q <= StStall;
            cnt_q   <= CntW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        StStall: begin
          if (any_match || !any_head) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else if (can_load) begin
            // Back-pressured cycles do not count towards the gap timeout.
            if (cnt_q == CntW'(STALL_LIMIT)) state_q <= StResync;
            else                             cnt_q   <= cnt_q + CntW'(1);
          end
        end
        StResync: begin
          gap_err <= 1'b1;
          if (min_found) expected_q <= min_order;
          state_q <= StRun;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StRun;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uvma_rvfi_retire_sched.sv
// Scoreboard bench for uvma_rvfi_retire_sched: a reorder model predicts the merged
// stream, a monitor pops and compares every accepted output.
module tb_uvma_rvfi_retire_sched;

  localparam int OW = 64;
  localparam int PW = 128;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    in_valid, in_ready;
  logic [NR*OW-1:0] in_order;
  logic [NR*PW-1:0] in_payload;
  logic             out_valid, out_ready;
  logic [OW-1:0]    out_order, expected;
  logic [PW-1:0]    out_payload;
  logic             dup_err, gap_err;
  logic [1:0]       state_o;

  logic [1:0]  w_in_valid, w_in_ready;
  logic [7:0]  w_in_order;
  logic [15:0] w_in_payload;
  logic        w_out_valid, w_out_ready;
  logic [3:0]  w_out_order, w_expected;
  logic [7:0]  w_out_payload;
  logic        w_dup, w_gap;
  logic [1:0]  w_state;

  uvma_rvfi_retire_sched #(
    .NRET(2), .ORDER_WL(64), .PAYLOAD_W(128), .DEPTH(4), .STALL_LIMIT(16), .ORDER_START(64'd0)
  ) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_order(in_order),
    .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
    .out_order(out_order), .out_payload(out_payload), .expected(expected),
    .dup_err(dup_err), .gap_err(gap_err), .state_o(state_o)
  );

  uvma_rvfi_retire_sched #(
    .NRET(2), .ORDER_WL(4), .PAYLOAD_W(8), .DEPTH(4), .STALL_LIMIT(16), .ORDER_START(4'd14)
  ) dut_wrap (
    .clk(clk), .reset(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_order(w_in_order), .in_payload(w_in_payload), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_order(w_out_order), .out_payload(w_out_payload),
    .expected(w_expected), .dup_err(w_dup), .gap_err(w_gap), .state_o(w_state)
  );

  typedef struct packed {logic [63:0] ord; logic [127:0] pay;} exp_t;
  typedef struct packed {logic [3:0] ord; logic [7:0] pay;} wexp_t;
  typedef struct {logic [63:0] ord; logic [127:0] pay; int dly;} item_t;
  typedef struct packed {logic [1:0] st; logic ov; logic [63:0] oo; logic [1:0] ir; logic [63:0] ex;} log_t;

  exp_t  sb[$];
  wexp_t sbw[$];
  item_t chq[NR][$];
  log_t  lg[$];
  int    pop_cyc[$];
  logic [127:0] pend[logic [63:0]];
  logic [63:0]  next_exp;
  bit           use_model;
  int           n_checks = 0;
  int           n_err = 0;
  int           cyc_g = 0;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_order", out_order, e.ord);
        chk("out_payload", out_payload, e.pay);
      end
      pop_cyc.push_back(cyc_g);
    end
  end

  always @(negedge clk) begin
    if (!rst && w_out_valid && w_out_ready) begin
      if (sbw.size() == 0) begin
        fail_now("wrap_unexpected_output");
      end else begin
        wexp_t e;
        e = sbw.pop_front();
        chk("wrap_out_order", w_out_order, e.ord);
        chk("wrap_out_payload", w_out_payload, e.pay);
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reorder model: release orders strictly consecutively from next_exp.
  task automatic issue(input logic [63:0] o, input logic [127:0] p);
    if (use_model) begin
      pend[o] = p;
      while (pend.exists(next_exp)) begin
        sb.push_back('{next_exp, pend[next_exp]});
        pend.delete(next_exp);
        next_exp++;
      end
    end
  endtask

  task automatic add(input int c, input logic [63:0] o, input int d);
    item_t it;
    it.ord = o;
    it.pay = rnd128();
    it.dly = d;
    chq[c].push_back(it);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0; in_order = '0; in_payload = '0; out_ready = 1'b0;
    w_in_valid = '0; w_in_order = '0; w_in_payload = '0; w_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete(); sbw.delete(); pend.delete(); lg.delete();
    next_exp = '0;
    for (int c = 0; c < NR; c++) chq[c].delete();
  endtask

  task automatic run_traffic(input int hold, input int pct, input int budget);
    int wl[NR];
    bit armed[NR];
    int cyc;
    bit done;
    for (int c = 0; c < NR; c++) begin wl[c] = 0; armed[c] = 0; end
    cyc = 0;
    done = 0;
    while (!done) begin
      for (int c = 0; c < NR; c++) begin
        in_valid[c] = 1'b0;
        if (chq[c].size() > 0) begin
          if (!armed[c]) begin armed[c] = 1; wl[c] = chq[c][0].dly; end
          if (wl[c] > 0) wl[c]--;
          else begin
            in_valid[c] = 1'b1;
            in_order[c*OW +: OW] = chq[c][0].ord;
            in_payload[c*PW +: PW] = chq[c][0].pay;
          end
        end
      end
      out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pct);
      @(negedge clk);
      lg.push_back('{state_o, out_valid, out_order, in_ready, expected});
      for (int c = 0; c < NR; c++) begin
        if (in_valid[c] && in_ready[c]) begin
          issue(chq[c][0].ord, chq[c][0].pay);
          void'(chq[c].pop_front());
          armed[c] = 0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (chq[0].size() == 0 && chq[1].size() == 0 && sb.size() == 0 && !out_valid) done = 1;
      else if (cyc >= budget) begin fail_now("traffic_timeout"); done = 1; end
    end
    in_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit stable;
    logic [127:0] pa, pb;
    logic [3:0] wo[4];
    int k;

    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_order", out_order, 0);
    chk("rst_out_payload", out_payload, 0);
    chk("rst_expected", expected, 0);
    chk("rst_dup_err", dup_err, 0);
    chk("rst_gap_err", gap_err, 0);
    chk("rst_state", state_o, 0);
    chk("rst_wrap_expected", w_expected, 14);

    // In-order interleave, no bubbles after the first output
    do_reset();
    use_model = 1;
    for (int i = 0; i < 6; i++) add(i % 2, i, 0);
    base = pop_cyc.size();
    run_traffic(0, 100, 100);
    chk("inord_count", pop_cyc.size() - base, 6);
    if (pop_cyc.size() - base == 6) chk("inord_span", pop_cyc[base+5] - pop_cyc[base], 5);
    chk("inord_expected", expected, 6);

    // Out of order: ch1 carries 1 at cycle 0, ch0 carries 0 at cycle 3
    do_reset();
    use_model = 1;
    add(1, 1, 0);
    add(0, 0, 3);
    run_traffic(0, 100, 100);
    if (lg.size() >= 6) begin
      chk("ooo_state_c1", lg[1].st, 0);
      chk("ooo_state_c2", lg[2].st, 1);
      chk("ooo_state_c3", lg[3].st, 1);
      chk("ooo_state_c4", lg[4].st, 1);
      chk("ooo_state_c5", lg[5].st, 0);
    end else fail_now("ooo_log_short");
    chk("ooo_gap_err", gap_err, 0);

    // Back-pressure: out_ready low for 10 cycles, 8 entries offered
    do_reset();
    use_model = 1;
    for (int i = 0; i < 8; i++) add(i % 2, i, 0);
    run_traffic(10, 100, 100);
    if (lg.size() >= 10) begin
      chk("bp_in_ready", lg[8].ir, 2'b01);
      stable = 1;
      for (int i = 2; i < 10; i++) if (!(lg[i].ov && lg[i].oo == 0)) stable = 0;
      chk("bp_out_stable", stable, 1);
    end else fail_now("bp_log_short");
    chk("bp_gap_err", gap_err, 0);
    chk("bp_expected", expected, 8);

    // Gap: lone order 5 while expecting 0
    do_reset();
    use_model = 0;
    add(0, 5, 0);
    sb.push_back('{64'd5, chq[0][0].pay});
    run_traffic(0, 100, 100);
    if (lg.size() >= 20) begin
      chk("gap_state_c16", lg[16].st, 1);
      chk("gap_state_c17", lg[17].st, 1);
      chk("gap_state_c18", lg[18].st, 2);
      chk("gap_state_c19", lg[19].st, 0);
      chk("gap_resync_expected", lg[19].ex, 5);
    end else fail_now("gap_log_short");
    chk("gap_gap_err", gap_err, 1);
    chk("gap_dup_err", dup_err, 0);
    chk("gap_expected_after", expected, 6);

    // Duplicate order 7 on both channels
    do_reset();
    use_model = 0;
    for (int i = 0; i < 7; i++) add(i % 2, i, 0);
    add(0, 7, 0);
    add(1, 7, 0);
    pa = chq[0][chq[0].size()-1].pay;
    pb = chq[1][chq[1].size()-1].pay;
    for (int i = 0; i < 7; i++) begin
      k = i % 2;
      sb.push_back('{64'(i), chq[k][i/2].pay});
    end
    sb.push_back('{64'd7, pa});
    sb.push_back('{64'd7, pb});
    run_traffic(0, 100, 100);
    chk("dup_dup_err", dup_err, 1);
    chk("dup_gap_err", gap_err, 1);
    chk("dup_expected", expected, 8);

    // Randomised channel split, delays and consumer stalls
    for (int it = 0; it < 4; it++) begin
      do_reset();
      use_model = 1;
      for (int o = 0; o < 40; o++) add($urandom_range(1), o, $urandom_range(2));
      run_traffic(0, 75, 1000);
      chk("rnd_gap_err", gap_err, 0);
      chk("rnd_dup_err", dup_err, 0);
      chk("rnd_expected", expected, 40);
    end

    // Asynchronous reset while an output is held
    do_reset();
    in_valid = 2'b01;
    in_order = '0;
    in_payload = rnd128();
    @(posedge clk);
    #1 in_valid = '0;
    k = 0;
    while (!out_valid && k < 5) begin @(posedge clk); #1; k++; end
    chk("pre_reset_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_in_ready", in_ready, 2'b11);
    chk("async_reset_expected", expected, 0);

    // Wrap with a 4-bit order: 14, 15, 0, 1
    do_reset();
    wo[0] = 4'd14; wo[1] = 4'd15; wo[2] = 4'd0; wo[3] = 4'd1;
    w_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_in_valid = 2'b01;
      w_in_order = {4'd0, wo[i]};
      w_in_payload = {8'd0, 8'($urandom())};
      sbw.push_back('{wo[i], w_in_payload[7:0]});
      @(posedge clk);
      #1;
    end
    w_in_valid = '0;
    k = 0;
    while ((sbw.size() != 0 || w_out_valid) && k < 20) begin @(posedge clk); #1; k++; end
    if (k >= 20) fail_now("wrap_drain_timeout");
    chk("wrap_expected", w_expected, 2);
    chk("wrap_gap_err", w_gap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
